// File: rtl/cmp_seq_if.sv
// Handshake bundle between a requesting datapath and the wide-operand compare
// sequencer. The requester owns the master modport, the sequencer the slave.
interface cmp_seq_if #(
   parameter int NBYTES = 4
) ();
   localparam int CW = $clog2(NBYTES + 1);

   logic                  in_valid;
   logic                  in_ready;
   logic [8*NBYTES-1:0]   a;
   logic [8*NBYTES-1:0]   b;
   logic                  out_valid;
   logic                  out_ready;
   logic                  greater;
   logic                  lesser;
   logic                  equal;
   logic [CW-1:0]         nbytes_used;
   logic                  busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, greater, lesser, equal, nbytes_used, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, greater, lesser, equal, nbytes_used, busy
   );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Wide unsigned compare sequencer: walks two NBYTES-wide operands MSB-first
// through one shared 8-bit magnitude comparator, one byte per cycle.
// Optional feature macro: CMP_EARLY_EXIT_EN. When defined the walk stops on the
// first unequal byte; when undefined every job takes exactly NBYTES cycles so
// timing never depends on the data.
module cmp_seq_ctrl #(
   parameter int NBYTES = 4,
   localparam int CW = $clog2(NBYTES + 1)
) (
   input logic       clk,
   input logic       rst,
   cmp_seq_if.slave  bus
);
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMP,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [NBYTES-1:0][7:0]   a_q, a_d;
   logic [NBYTES-1:0][7:0]   b_q, b_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     vgt_q, vgt_d;
   logic                     vlt_q, vlt_d;
   logic                     greater_q, greater_d;
   logic                     lesser_q, lesser_d;
   logic                     equal_q, equal_d;
   logic [CW-1:0]            nbytes_q, nbytes_d;

   logic [7:0]               cur_a;
   logic [7:0]               cur_b;
   logic                     byte_gt;
   logic                     byte_lt;
   logic                     held;
   logic                     new_gt;
   logic                     new_lt;
   logic                     exit_now;

   // The single time-shared 8-bit magnitude comparator fed with the current byte
   always_comb begin
      cur_a   = a_q[idx_q];
      cur_b   = b_q[idx_q];
      byte_gt = (cur_a > cur_b);
      byte_lt = (cur_a < cur_b);
   end

   // Sticky verdict merge: the first unequal byte from the MSB side wins, and
   // the decision to leave the compare loop
   always_comb begin
      held   = vgt_q | vlt_q;
      new_gt = held ? vgt_q : byte_gt;
      new_lt = held ? vlt_q : byte_lt;
`ifdef CMP_EARLY_EXIT_EN
      exit_now = (idx_q == '0) | byte_gt | byte_lt;
`else
      exit_now = (idx_q == '0);
`endif
   end

   // Next-state and next-output computation for the sequencer
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      vgt_d     = vgt_q;
      vlt_d     = vlt_q;
      greater_d = greater_q;
      lesser_d  = lesser_q;
      equal_d   = equal_q;
      nbytes_d  = nbytes_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               idx_d   = IW'(NBYTES - 1);
               cnt_d   = '0;
               vgt_d   = 1'b0;
               vlt_d   = 1'b0;
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            cnt_d = cnt_q + CW'(1);
            vgt_d = new_gt;
            vlt_d = new_lt;
            if (exit_now) begin
               greater_d = new_gt;
               lesser_d  = new_lt;
               equal_d   = ~new_gt & ~new_lt;
               nbytes_d  = cnt_q + CW'(1);
               state_d   = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // All sequencer state and registered result outputs; reset discards any job
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         vgt_q     <= 1'b0;
         vlt_q     <= 1'b0;
         greater_q <= 1'b0;
         lesser_q  <= 1'b0;
         equal_q   <= 1'b0;
         nbytes_q  <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         vgt_q     <= vgt_d;
         vlt_q     <= vlt_d;
         greater_q <= greater_d;
         lesser_q  <= lesser_d;
         equal_q   <= equal_d;
         nbytes_q  <= nbytes_d;
      end
   end

   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.out_valid   = (state_q == S_DONE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.greater     = greater_q;
   assign bus.lesser      = lesser_q;
   assign bus.equal       = equal_q;
   assign bus.nbytes_used = nbytes_q;
endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Sequencer that compares two wide unsigned operands (NBYTES × 8 bits) by time-sharing one instance of the team's 8-bit magnitude comparator (cmp8, GREATER/LESSER outputs).
- Bytes are fed MSB-first, one per cycle.
- Operands arrive and results leave through valid/ready handshakes.
- Sits between a requesting datapath (sort/max-finder units) and the shared comparator.

Parameters:
- NBYTES, 4, operand width in bytes; legal range ≥1.
- CW, $clog2(NBYTES+1), width of the byte-count output (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair; high only in IDLE.
- a  in  8*NBYTES  operand A, unsigned; byte k = a[8k+7:8k].
- b  in  8*NBYTES  operand B, unsigned.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- greater  out  1  A > B.
- lesser  out  1  A < B.
- equal  out  1  A == B.
- nbytes_used  out  CW  number of byte comparisons performed for this result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; greater=lesser=equal=0; nbytes_used=0; busy=0; internal index and operand registers cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a and b into internal registers, set idx=NBYTES-1, clear the sticky verdict, go to CMP.
  - Inputs a and b are ignored after capture.
- CMP:
  - Each cycle, drive byte idx of both captured operands into cmp8.
  - Sticky verdict: if no verdict is held yet and GREATER or LESSER is asserted, latch gt/lt. The first unequal byte from the MSB side decides.
  - Increment the used-byte counter every CMP cycle.
  - Leave CMP on the edge when idx==0 has been compared, or earlier per CMP_EARLY_EXIT_EN.
  - Otherwise decrement idx.
- Transition CMP->DONE registers the outputs:
  - greater/lesser from the sticky verdict, or from the current byte when it decides.
  - equal = !greater & !lesser.
  - nbytes_used = count including the current byte.
- DONE:
  - out_valid=1; outputs held stable until out_valid&out_ready.
  - On that handshake go to IDLE and clear out_valid. Result outputs keep their value until the next DONE entry.
- Latency from accept edge to out_valid high: j cycles, where j = bytes examined (1..NBYTES).
- Throughput: one bubble cycle in IDLE between jobs; no acceptance while busy.
- Invariants:
  - Exactly one of greater/lesser/equal is high whenever out_valid=1.
  - greater & lesser is never 1.
- NBYTES=1: one CMP cycle, then DONE.
- out_ready held low: stay in DONE indefinitely; in_valid is ignored (in_ready=0).
- in_valid and out_ready asserted in the same DONE cycle: only the result handshake happens; the new operand is accepted in the following IDLE cycle.
- Reset asserted mid-CMP or mid-DONE: job discarded, no out_valid pulse after reset release.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: CMP also exits on the first byte where GREATER|LESSER=1. Latency = index-from-MSB of the first unequal byte + 1, or NBYTES if equal.
- Undefined: constant-time mode. Always NBYTES CMP cycles and nbytes_used=NBYTES. The result comes from the sticky first-unequal verdict. Timing is independent of data.

Test Plan (NBYTES=4):
- Reset, then release: in_ready=1, out_valid=0, greater=lesser=equal=0, busy=0 → all hold before any in_valid.
- a=0x12345678, b=0x12345678 → equal=1, nbytes_used=4, out_valid rises 4 cycles after accept (both modes).
- a=0x80000000, b=0x7FFFFFFF:
  - EARLY_EXIT: greater=1, nbytes_used=1, latency 1.
  - Without: greater=1, nbytes_used=4, latency 4.
- a=0x12340000, b=0x1234FFFF → lesser=1. Lower-byte verdicts must not override the sticky result. nbytes_used=3 (early exit) or 4.
- Backpressure and back-to-back:
  - Stimulus: out_ready=0 for 10 cycles while in_valid is held with the next pair (a=1, b=2).
  - Result stable, in_ready=0. Then out_ready=1 → IDLE bubble, second job gives lesser=1.
- Reset mid-CMP: assert rst during cycle 2 of a 4-byte compare → immediate IDLE, all outputs 0, no out_valid. The next job a=5, b=3 gives greater=1.
